// File: rtl/alu_pipe_sequencer.sv
// Program sequencer for a fixed-latency pipelined ALU: fetches {opcode, a, b}
// words, issues one per cycle, and writes each result back tagged with its address.
module alu_pipe_sequencer #(
  parameter int WIDTH   = 8,
  parameter int ADDR_W  = 4,
  parameter int ALU_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W:0]      prog_len,
  input  logic                 hold,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [3*WIDTH-1:0]   imem_rdata,
  output logic [WIDTH-1:0]     alu_opcode,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 alu_valid,
  input  logic [WIDTH-1:0]     alu_y,
  output logic                 res_we,
  output logic [ADDR_W-1:0]    res_addr,
  output logic [WIDTH-1:0]     res_data,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] PC_ONE = 1;

  state_t                           state_q, state_d;
  logic [ADDR_W:0]                  pc_q, pc_d;
  logic [ADDR_W:0]                  len_q, len_d;
  logic [ADDR_W-1:0]                fa_q, fa_d;
  logic                             fv_q, fv_d;
  logic [WIDTH-1:0]                 op_q, op_d;
  logic [WIDTH-1:0]                 a_q, a_d;
  logic [WIDTH-1:0]                 b_q, b_d;
  logic                             alu_valid_q, alu_valid_d;
  logic [ADDR_W-1:0]                tag_q, tag_d;
  logic [ALU_LAT-1:0]               chain_v_q, chain_v_d;
  logic [ALU_LAT-1:0][ADDR_W-1:0]   chain_tag_q, chain_tag_d;
  logic                             res_we_q, res_we_d;
  logic [ADDR_W-1:0]                res_addr_q, res_addr_d;
  logic [WIDTH-1:0]                 res_data_q, res_data_d;
  logic                             zero_done_q, zero_done_d;
  logic                             issue;
  logic                             drain_done;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    fa_d        = fa_q;
    fv_d        = fv_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_valid_d = 1'b0;
    tag_d       = tag_q;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;
    zero_done_d = 1'b0;
    imem_addr   = '0;
    drain_done  = 1'b0;
    issue       = (state_q == RUN) && fv_q && !hold;

    // The tracking chain shifts unconditionally: the ALU itself cannot stall.
    chain_v_d      = chain_v_q;
    chain_tag_d    = chain_tag_q;
    chain_v_d[0]   = alu_valid_q;
    chain_tag_d[0] = tag_q;
    for (int i = 1; i < ALU_LAT; i++) begin
      chain_v_d[i]   = chain_v_q[i-1];
      chain_tag_d[i] = chain_tag_q[i-1];
    end

    res_we_d = chain_v_q[ALU_LAT-1];
    if (chain_v_q[ALU_LAT-1]) begin
      res_addr_d = chain_tag_q[ALU_LAT-1];
      res_data_d = alu_y;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (prog_len != '0) begin
            len_d   = prog_len;
            pc_d    = '0;
            fv_d    = 1'b0;
            state_d = RUN;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (fv_q && hold) begin
          // Replay: re-present the held address so the word is still there next cycle.
          imem_addr = fa_q;
        end else begin
          imem_addr = pc_q[ADDR_W-1:0];
          if (pc_q < len_q) begin
            fa_d = pc_q[ADDR_W-1:0];
            fv_d = 1'b1;
            pc_d = pc_q + PC_ONE;
          end else begin
            fv_d = 1'b0;
          end
        end

        if (issue) begin
          op_d        = imem_rdata[3*WIDTH-1:2*WIDTH];
          a_d         = imem_rdata[2*WIDTH-1:WIDTH];
          b_d         = imem_rdata[WIDTH-1:0];
          alu_valid_d = 1'b1;
          tag_d       = fa_q;
        end

        if ((pc_q == len_q) && !fv_q && !alu_valid_q) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if ((chain_v_q == '0) && !res_we_q) begin
          drain_done = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      fa_q        <= '0;
      fv_q        <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      alu_valid_q <= 1'b0;
      tag_q       <= '0;
      chain_v_q   <= '0;
      chain_tag_q <= '0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      fa_q        <= fa_d;
      fv_q        <= fv_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_valid_q <= alu_valid_d;
      tag_q       <= tag_d;
      chain_v_q   <= chain_v_d;
      chain_tag_q <= chain_tag_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_valid  = alu_valid_q;
  assign res_we     = res_we_q;
  assign res_addr   = res_addr_q;
  assign res_data   = res_data_q;
  assign done       = drain_done | zero_done_q;
  assign busy       = (state_q != IDLE) && !drain_done;

endmodule

// File: tb/tb_alu_pipe_sequencer.sv
// Scoreboard bench for alu_pipe_sequencer: a 3-stage add ALU model and a
// synchronous instruction memory surround the DUT; a monitor checks each write.
module tb_alu_pipe_sequencer;
  localparam int W   = 8;
  localparam int AW  = 4;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [AW:0]       prog_len = '0;
  logic              hold = 1'b0;
  logic [AW-1:0]     imem_addr;
  logic [3*W-1:0]    imem_rdata = '0;
  logic [W-1:0]      alu_opcode, alu_a, alu_b, alu_y;
  logic              alu_valid;
  logic              res_we;
  logic [AW-1:0]     res_addr;
  logic [W-1:0]      res_data;
  logic              busy, done;

  alu_pipe_sequencer #(.WIDTH(W), .ADDR_W(AW), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_len(prog_len), .hold(hold),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_valid(alu_valid),
    .alu_y(alu_y), .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            cyc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  int           base = 0;
  logic [3*W-1:0] mem [16];
  logic [W-1:0] p1 = '0, p2 = '0, p3 = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read instruction memory and 3-cycle ALU (opcode 0x01 = add).
  always @(posedge clk) imem_rdata <= mem[imem_addr];
  always @(posedge clk) begin
    p1 <= (alu_opcode == 8'h01) ? alu_a + alu_b : alu_a ^ alu_b;
    p2 <= p1;
    p3 <= p2;
  end
  assign alu_y = p3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int addr, input int data, input int c);
    exp_t e;
    e.addr = addr[AW-1:0];
    e.data = data[W-1:0];
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // Monitor: every write is popped against the scoreboard.
  always @(negedge clk) begin
    if (!reset && res_we) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res_we", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("res_addr", 32'(res_addr), 32'(mon_e.addr));
        check("res_data", 32'(res_data), 32'(mon_e.data));
        check("res_cycle", cyc - base, mon_e.cyc);
      end
    end
  end

  task automatic load3();
    mem[0] = {8'h01, 8'h03, 8'h04};
    mem[1] = {8'h01, 8'h10, 8'h20};
    mem[2] = {8'h01, 8'hFF, 8'h01};
  endtask

  // Start is accepted at the next edge; cycle 0 begins right after it.
  task automatic start_prog(input int len);
    @(negedge clk);
    prog_len = len[AW:0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    base  = cyc;
    start = 1'b0;
  endtask

  task automatic run_prog(input int len, input int hold_lo, input int hold_hi,
                          input int mid_start, input int exp_done);
    int  done_cyc;
    int  n_done;
    logic busy_ok;
    done_cyc = -1;
    n_done   = 0;
    busy_ok  = 1'b1;
    start_prog(len);
    for (int r = 0; r < 60; r++) begin
      hold = (r >= hold_lo) && (r <= hold_hi);
      if (r == mid_start) begin
        start    = 1'b1;
        prog_len = 5'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = r;
      end
      if (r >= 1 && r < exp_done && !busy) busy_ok = 1'b0;
      if (r == exp_done) check("busy_low_at_done", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      if (done_cyc >= 0 && r > done_cyc + 1) break;
    end
    hold  = 1'b0;
    start = 1'b0;
    check("done_cycle", done_cyc, exp_done);
    check("done_pulses", n_done, 1);
    check("busy_during_run", 32'(busy_ok), 32'd1);
    check("all_results_seen", sb_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_we;
    int n_dn;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset state
    #12;
    check("rst_alu_valid", 32'(alu_valid), 32'd0);
    check("rst_res_we", 32'(res_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic 3-instruction program
    load3();
    push(0, 8'h07, 6);
    push(1, 8'h30, 7);
    push(2, 8'h00, 8);
    run_prog(3, 99, 99, 99, 9);

    // Hold in cycles 2..4: replayed fetch, 3-cycle result gap
    push(0, 8'h07, 6);
    push(1, 8'h30, 10);
    push(2, 8'h00, 11);
    run_prog(3, 2, 4, 99, 12);

    // Zero-length program
    start_prog(0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_alu_valid", 32'(alu_valid), 32'd0);
    check("zero_res_we", 32'(res_we), 32'd0);
    @(negedge clk);
    check("zero_done_once", 32'(done), 32'd0);
    check("zero_busy_after", 32'(busy), 32'd0);

    // Full memory
    for (int i = 0; i < 16; i++) begin
      mem[i] = {8'h01, 8'(i), 8'(3 * i)};
      push(i, (4 * i) & 8'hFF, 6 + i);
    end
    run_prog(16, 99, 99, 99, 22);

    // Start pulsed mid-run with a different length is ignored
    load3();
    push(0, 8'h07, 6);
    push(1, 8'h30, 7);
    push(2, 8'h00, 8);
    run_prog(3, 99, 99, 2, 9);

    // Reset with two ops in flight
    start_prog(3);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("inflight_alu_valid", 32'(alu_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_alu_valid", 32'(alu_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_res_we", 32'(res_we), 32'd0);
    check("arst_imem_addr", 32'(imem_addr), 32'd0);
    check("arst_alu_opcode", 32'(alu_opcode), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_we = 0;
    n_dn = 0;
    for (int r = 0; r < 15; r++) begin
      @(negedge clk);
      if (res_we) n_we++;
      if (done) n_dn++;
    end
    check("post_reset_no_res_we", n_we, 0);
    check("post_reset_no_done", n_dn, 0);

    // Clean restart from address 0
    push(0, 8'h07, 6);
    push(1, 8'h30, 7);
    push(2, 8'h00, 8);
    run_prog(3, 99, 99, 99, 9);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_pipe_sequencer.md
Name: alu_pipe_sequencer

Overview:
- Program sequencer for the 3-stage pipelined ALU.
- On `start`, it walks a synchronous-read instruction memory. Each word is `{opcode, a, b}`.
- It issues one instruction per cycle into the ALU and tracks in-flight operations with a valid/tag shift chain.
- It writes each ALU result back with the address of the instruction that produced it, then pulses `done`.
- It sits between the instruction memory, the ALU pipeline and a result memory or scoreboard.

Parameters:
- WIDTH, 8, operand, opcode and result width.
- ADDR_W, 4, instruction/result address width; maximum program length is 2^ADDR_W.
- ALU_LAT, 3, cycles from operands presented (with `alu_valid`) to matching `alu_y`; the ALU has no stall input.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  start program; sampled only in IDLE
- prog_len  in  ADDR_W+1  number of instructions; sampled with `start`
- hold  in  1  issue back-pressure; in-flight ops still complete
- imem_addr  out  ADDR_W  instruction memory address; combinational
- imem_rdata  in  3*WIDTH  `{opcode[3W-1:2W], a[2W-1:W], b[W-1:0]}`; word for the previous cycle's `imem_addr`
- alu_opcode  out  WIDTH  registered issue opcode
- alu_a  out  WIDTH  registered operand a
- alu_b  out  WIDTH  registered operand b
- alu_valid  out  1  registered; issue slot is a real instruction
- alu_y  in  WIDTH  ALU result, ALU_LAT cycles after issue
- res_we  out  1  registered result write strobe
- res_addr  out  ADDR_W  registered; instruction index of result
- res_data  out  WIDTH  registered result
- busy  out  1  high from the cycle after start acceptance until `done`
- done  out  1  one-cycle pulse at program end

Behaviour:
- Reset (async): all outputs 0. State IDLE; `pc`=0; fetch-valid `fv`=0; valid chain and tags cleared.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start`=1 and `prog_len`!=0: latch `prog_len`, `pc`<=0, `fv`<=0, go to RUN.
  - `start`=1 and `prog_len`=0: pulse `done` next cycle, stay IDLE, `busy` stays 0.
  - `imem_addr`=0.
- Fetch registers: `pc` is the next address to fetch. `fa` is the address whose data is on `imem_rdata` this cycle; `fv` flags it valid.
- `issue` = `fv` & !`hold`.
- RUN, each cycle:
  - If `issue` or !`fv`, fetch: `imem_addr`=`pc`. If `pc`<`len`: `fa`<=`pc`, `fv`<=1, `pc`<=`pc`+1. Otherwise `fv`<=0.
  - If `fv` & `hold` (replay): `imem_addr`=`fa`; `pc`, `fa` and `fv` unchanged; bubble issued.
  - Issue register load: on `issue`, load `alu_opcode`/`alu_a`/`alu_b` from `imem_rdata`, set `alu_valid`<=1 and tag <=`fa`. Otherwise `alu_valid`<=0 and operands hold their value.
- Tracking: an ALU_LAT-deep shift chain of `{valid, tag}`, entered from `alu_valid`/tag and shifting every cycle regardless of `hold`.
  - When the chain output valid is 1, register `res_we`<=1, `res_addr`<=tag, `res_data`<=`alu_y`. Otherwise `res_we`<=0.
- Latency: start accepted at edge E0 → `imem_addr`=0 in cycle 0 → `alu_valid` in cycle 2 → `res_we` for instruction 0 in cycle ALU_LAT+3.
  - Without `hold`, results are back-to-back in address order.
- RUN→DRAIN: when `pc`==`len`, `fv`=0 and `alu_valid`=0.
- DRAIN→IDLE: when the chain and `res_we` are all 0. `done`=1 for that one cycle; `busy` drops the same cycle.
- `start` while `busy` is ignored. `prog_len` changes after acceptance have no effect.
- Width rule: `pc` is ADDR_W+1 bits so that `prog_len`=2^ADDR_W works; `imem_addr` and `res_addr` are its low ADDR_W bits.
- `hold` in IDLE or DRAIN has no effect.
- Reset mid-program: all activity stops immediately. No `res_we` and no `done` until a new `start`.

Test Plan:
- Bench ALU model with 3-cycle latency, opcode 0x01 = add. Load mem[0..2] = {01,03,04}, {01,10,20}, {01,FF,01}. `start`, `prog_len`=3 → `res_we` in cycles 6, 7, 8 with addr/data 0/07, 1/30, 2/00. `done` in cycle 9 only; `busy` high cycles 1–8.
- Same program, `hold`=1 during cycles 2–4 → bubbles on `alu_valid`; results still 07, 30, 00 in address order, each exactly once, with a 3-cycle gap after the first issue stall. No duplicate or skipped address.
- `prog_len`=0 with `start` → `done` pulses one cycle later; `alu_valid`, `res_we` and `busy` stay 0.
- `prog_len`=16 (full memory), no `hold` → 16 consecutive `res_we`, addresses 0..15. `imem_addr` never exceeds 15; `done` follows the last write.
- `start` pulsed again mid-run → ignored; result count stays at `prog_len`.
- Assert `reset` while 2 ops are in flight → all outputs 0 asynchronously. No further `res_we` or `done`. A new `start` runs cleanly from address 0.
